arst_sync_seq: RTL and testbench

ARST_SYNC_SEQ -- requirements
Module: arst_sync_seq

---
 rtl/arst_seq_pkg.sv | 8 +
 rtl/arst_sync_chain.sv | 14 +
 rtl/arst_sync_seq.sv | 85 ++++++++
 tb/tb_arst_sync_seq.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/arst_seq_pkg.sv
// arst_seq_pkg: shared FSM state type and default parameter values for the reset sequencer.
package arst_seq_pkg;
  typedef enum logic [1:0] {HOLD, SYNC_WAIT, SEQ, RUN} state_e;
  localparam int CH_DEF            = 4;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int GAP_CYCLES_DEF    = 4;
  localparam int FILTER_CYCLES_DEF = 3;
endpackage

// File: rtl/arst_sync_chain.sv
// arst_sync_chain: reset-deassertion synchroniser, async clear, D tied high.
module arst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_ni,
  output logic sync_o
);
  logic [STAGES-1:0] chain_q;
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) chain_q <= '0;
    else chain_q <= {chain_q[STAGES-2:0], 1'b1};
  assign sync_o = chain_q[STAGES-1];
endmodule

// File: rtl/arst_sync_seq.sv
// arst_sync_seq: sequenced per-channel reset release with async assert and soft reset.
// Define ARST_SEQ_FILTER_EN to require FILTER_CYCLES consecutive swrst_i highs before acceptance.
module arst_sync_seq
  import arst_seq_pkg::*;
#(
  parameter int CH            = CH_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          swrst_i,
  output logic [CH-1:0] rst_o,
  output logic          done_o
);
  localparam int IW = CH > 1 ? $clog2(CH) : 1;
  if (CH < 1 || CH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || GAP_CYCLES < 1 ||
      GAP_CYCLES > 255 || FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_cfg
    $error("arst_sync_seq: parameter out of range");
  end
  state_e        state_q, state_d;
  logic [CH-1:0] rst_q, rst_d;
  logic [7:0]    gap_q, gap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sync, accept;
  arst_sync_chain #(.STAGES(SYNC_STAGES)) u_chain (
    .clk   (clk),
    .rst_ni(rst_ni),
    .sync_o(sync)
  );
`ifdef ARST_SEQ_FILTER_EN
  logic [3:0] filt_q;
  assign accept = swrst_i && filt_q == 4'(FILTER_CYCLES - 1);
  // Saturates once accepted so a held request keeps re-asserting the outputs.
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) filt_q <= '0;
    else filt_q <= swrst_i ? (accept ? filt_q : filt_q + 4'd1) : '0;
`else
  assign accept = swrst_i;
`endif
  always_comb begin
    state_d = state_q;
    rst_d   = rst_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = HOLD;
      rst_d   = '1;
      gap_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        // Leaving HOLD reuses SYNC_WAIT; the chain is already settled so release follows next edge.
        HOLD: state_d = swrst_i ? HOLD : SYNC_WAIT;
        SYNC_WAIT: if (sync) begin
          rst_d[0] = 1'b0;
          idx_d    = IW'(1);
          state_d  = CH == 1 ? RUN : SEQ;
        end
        SEQ: if (gap_q == 8'(GAP_CYCLES - 1)) begin
          rst_d[idx_q] = 1'b0;
          gap_d        = '0;
          idx_d        = idx_q + IW'(1);
          state_d      = idx_q == IW'(CH - 1) ? RUN : SEQ;
        end else gap_d = gap_q + 8'd1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= SYNC_WAIT;
      rst_q   <= '1;
      gap_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rst_q   <= rst_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
    end
  assign rst_o  = rst_q;
  assign done_o = state_q == RUN;
endmodule

// File: tb/tb_arst_sync_seq.sv
// tb_arst_sync_seq: directed and randomized checks of arst_sync_seq against an edge-count reference model.
module tb_arst_sync_seq;
  localparam int SS  = 2;
  localparam int GAP = 4;
`ifdef ARST_SEQ_FILTER_EN
  localparam int FC = 3;
`else
  localparam int FC = 1;
`endif
  logic       clk = 1'b0, rst_ni = 1'b1, swrst_i = 1'b0;
  logic [2:0] rst_o;
  logic       done_o;
  logic [0:0] rst1_o;
  logic       done1_o;
  int  errors = 0, checks = 0;
  int  m_cnt = 0, m_base = SS + 1, m_filt = 0;
  bit  m_hold = 1'b0;
  always #5 clk = ~clk;
  arst_sync_seq #(.CH(3), .SYNC_STAGES(SS), .GAP_CYCLES(GAP), .FILTER_CYCLES(3)) u_dut (
    .clk(clk), .rst_ni(rst_ni), .swrst_i(swrst_i), .rst_o(rst_o), .done_o(done_o)
  );
  arst_sync_seq #(.CH(1), .SYNC_STAGES(SS), .GAP_CYCLES(1), .FILTER_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_ni(rst_ni), .swrst_i(swrst_i), .rst_o(rst1_o), .done_o(done1_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // Channel k is released once m_cnt edges have elapsed past base + k*gap since the origin.
  function automatic logic [31:0] exp_rst(input int ch, input int gap);
    logic [31:0] e = '0;
    for (int k = 0; k < ch; k++) e[k] = m_hold || m_cnt < m_base + k * gap;
    return e;
  endfunction
  function automatic logic [31:0] exp_done(input int ch, input int gap);
    return {31'b0, !m_hold && m_cnt >= m_base + (ch - 1) * gap};
  endfunction
  task automatic model_reset();
    m_hold = 1'b0;
    m_cnt  = 0;
    m_base = SS + 1;
    m_filt = 0;
  endtask
  task automatic model_edge();
    if (!rst_ni) return;
    m_filt = swrst_i ? m_filt + 1 : 0;
    if (swrst_i && m_filt >= FC) m_hold = 1'b1;
    else if (m_hold && !swrst_i) begin
      m_hold = 1'b0;
      m_cnt  = 0;
      m_base = 1;
    end else if (!m_hold && m_cnt < 100000) m_cnt++;
  endtask
  task automatic compare(input string tag);
    chk({tag, "_rst"}, rst_o, exp_rst(3, GAP));
    chk({tag, "_done"}, done_o, exp_done(3, GAP));
    chk({tag, "_rst1"}, rst1_o, exp_rst(1, 1));
    chk({tag, "_done1"}, done1_o, exp_done(1, 1));
    chk({tag, "_order"}, (!rst_o[0] || rst_o[1]) && (!rst_o[1] || rst_o[2]), 1);
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask
  task automatic arst_pulse(input string tag);
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare(tag);
    chk({tag, "_async"}, {rst_o, done_o}, 4'b1110);
    #1 rst_ni = 1'b1;
  endtask
  initial begin
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    compare("por");
    chk("por_rst", rst_o, 3'b111);
    chk("por_done", done_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      step("pwr");
      if (n == 2) chk("pwr_e2", {rst_o, rst1_o, done1_o}, 5'b11110);
      if (n == 3) chk("pwr_e3", {rst_o, rst1_o, done1_o}, 5'b11001);
      if (n == 6) chk("pwr_e6", rst_o, 3'b110);
      if (n == 7) chk("pwr_e7", rst_o, 3'b100);
      if (n == 10) chk("pwr_e10", {rst_o, done_o}, 4'b1000);
      if (n == 11) chk("pwr_e11", {rst_o, done_o}, 4'b0001);
    end
    arst_pulse("rst_a");
    for (int n = 1; n <= 8; n++) step("mid");
    arst_pulse("mid_pulse");
    for (int n = 1; n <= 11; n++) begin
      step("mid_re");
      if (n == 3) chk("mid_e3", rst_o, 3'b110);
      if (n == 11) chk("mid_e11", {rst_o, done_o}, 4'b0001);
    end
    swrst_i = 1'b1;
    repeat (FC) step("srun");
    chk("srun_hold", {rst_o, done_o, rst1_o, done1_o}, 6'b111010);
    swrst_i = 1'b0;
    step("srun_e0");
    for (int n = 1; n <= 9; n++) begin
      step("srun_rel");
      if (n == 1) chk("srun_e1", rst_o, 3'b110);
      if (n == 8) chk("srun_e8", rst_o, 3'b100);
      if (n == 9) chk("srun_e9", {rst_o, done_o}, 4'b0001);
    end
`ifdef ARST_SEQ_FILTER_EN
    swrst_i = 1'b1;
    repeat (2) step("filt_b1");
    chk("filt_b1", rst_o, 3'b000);
    swrst_i = 1'b0;
    step("filt_gap");
    swrst_i = 1'b1;
    repeat (2) step("filt_b2");
    chk("filt_b2_2", rst_o, 3'b000);
    step("filt_b2");
    chk("filt_b2_3", rst_o, 3'b111);
    swrst_i = 1'b0;
    repeat (12) step("filt_rel");
`endif
    arst_pulse("rst_b");
    for (int n = 1; n <= 8; n++) step("sseq");
    swrst_i = 1'b1;
    for (int n = 0; n < FC; n++) begin
      step("sseq_acc");
      chk("sseq_ch2", rst_o[2], 1);
    end
    chk("sseq_hold", rst_o, 3'b111);
    swrst_i = 1'b0;
    repeat (12) step("sseq_rel");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) arst_pulse("rnd_arst");
      else swrst_i = swrst_i ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
